// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared codes and state encoding for the RV32 memory stage.
package mem_stage_pkg;
    localparam logic [2:0] LB_F3  = 3'b000;
    localparam logic [2:0] LH_F3  = 3'b001;
    localparam logic [2:0] LW_F3  = 3'b010;
    localparam logic [2:0] LBU_F3 = 3'b100;
    localparam logic [2:0] LHU_F3 = 3'b101;
    localparam logic [2:0] SB_F3  = 3'b000;
    localparam logic [2:0] SH_F3  = 3'b001;
    localparam logic [2:0] SW_F3  = 3'b010;
    localparam logic [31:0] LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] STORE_MISALIGN = 32'd6;
    typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_RESP} mem_state_e;
endpackage

// File: rtl/mem_stage_align.sv
// mem_align: store lane replication/strobes, load extract/extend, misalign and funct3 legality.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o,
    output logic        unsupported_o
);
    logic [31:0] sh;
    assign sh = rdata_i >> {addr_lo_i, 3'b000};
    assign load_data_o = funct3_i == LB_F3  ? {{24{sh[7]}}, sh[7:0]} :
                         funct3_i == LH_F3  ? {{16{sh[15]}}, sh[15:0]} :
                         funct3_i == LBU_F3 ? {24'b0, sh[7:0]} :
                         funct3_i == LHU_F3 ? {16'b0, sh[15:0]} : rdata_i;
    assign unsupported_o = is_store_i ? (funct3_i[2] | (funct3_i[1:0] == 2'b11))
                                      : ((funct3_i[1:0] == 2'b11) | (funct3_i == 3'b110));
    assign misalign_o = ~unsupported_o & (funct3_i[1:0] == 2'b01 ? addr_lo_i[0] :
                                          funct3_i[1:0] == 2'b10 ? |addr_lo_i : 1'b0);
    assign wdata_o = funct3_i[1:0] == 2'b00 ? {4{store_data_i[7:0]}} :
                     funct3_i[1:0] == 2'b01 ? {2{store_data_i[15:0]}} : store_data_i;
    assign wstrb_o = funct3_i[1:0] == 2'b00 ? 4'b0001 << addr_lo_i :
                     funct3_i[1:0] == 2'b01 ? 4'b0011 << addr_lo_i : 4'b1111;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory stage driving a valid/ready data bus and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_valid,
    input  logic              ex_mem_mem_ren,
    input  logic              ex_mem_mem_wen,
    input  logic [2:0]        ex_mem_funct3,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_store_data,
    input  logic [4:0]        ex_mem_rd_addr,
    input  logic              ex_mem_rd_wen,
    input  logic [DATA_W-1:0] ex_mem_rd_data,
    input  logic [31:0]       ex_mem_pc,
    output logic              dbus_req_valid,
    input  logic              dbus_req_ready,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [DATA_W-1:0] dbus_wdata,
    output logic [3:0]        dbus_wstrb,
    input  logic              dbus_resp_valid,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              mem_stall,
    output logic              mem_wb_valid,
    output logic [4:0]        mem_wb_rd_addr,
    output logic              mem_wb_rd_wen,
    output logic [DATA_W-1:0] mem_wb_rd_data,
    output logic              mem_csr_trap_valid,
    output logic [31:0]       mem_csr_trap_cause,
    output logic [31:0]       mem_csr_trap_pc,
    output logic [31:0]       mem_csr_trap_tval
);
    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rd_wen_q, rd_wen_d, store_q, store_d;
    logic              wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              trap_q, trap_d;
    logic [31:0]       cause_q, cause_d, tpc_q, tpc_d, tval_q, tval_d;
    logic              idle, req, is_mem, start, al_mis, al_unsup;
    logic [DATA_W-1:0] al_wdata, al_load;
    logic [3:0]        al_wstrb;

    assign idle   = state_q == MEM_IDLE;
    assign req    = state_q == MEM_REQ;
    assign is_mem = ex_mem_mem_ren | ex_mem_mem_wen;
    assign start  = idle & ex_mem_valid & is_mem & ~al_unsup & ~al_mis;

    // Aligner sees the incoming op while idle and the latched op afterwards
    mem_align u_align (
        .is_store_i    (idle ? ex_mem_mem_wen : store_q),
        .funct3_i      (idle ? ex_mem_funct3 : f3_q),
        .addr_lo_i     (idle ? ex_mem_addr[1:0] : addr_q[1:0]),
        .store_data_i  (idle ? ex_mem_store_data : data_q),
        .rdata_i       (dbus_rdata),
        .wdata_o       (al_wdata),
        .wstrb_o       (al_wstrb),
        .load_data_o   (al_load),
        .misalign_o    (al_mis),
        .unsupported_o (al_unsup)
    );

    assign dbus_req_valid = req;
    assign dbus_we        = req & store_q;
    assign dbus_addr      = req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dbus_wdata     = req ? al_wdata : '0;
    assign dbus_wstrb     = (req & store_q) ? al_wstrb : 4'b0000;
    assign mem_stall      = start | req | (state_q == MEM_RESP & ~dbus_resp_valid);

    assign mem_wb_valid       = wb_valid_q;
    assign mem_wb_rd_addr     = wb_addr_q;
    assign mem_wb_rd_wen      = wb_wen_q;
    assign mem_wb_rd_data     = wb_data_q;
    assign mem_csr_trap_valid = trap_q;
    assign mem_csr_trap_cause = cause_q;
    assign mem_csr_trap_pc    = tpc_q;
    assign mem_csr_trap_tval  = tval_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        f3_d       = f3_q;
        data_d     = data_q;
        rd_addr_d  = rd_addr_q;
        rd_wen_d   = rd_wen_q;
        store_d    = store_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_wen_d   = wb_wen_q;
        wb_data_d  = wb_data_q;
        trap_d     = 1'b0;
        cause_d    = cause_q;
        tpc_d      = tpc_q;
        tval_d     = tval_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (start) begin
                    state_d   = MEM_REQ;
                    addr_d    = ex_mem_addr;
                    f3_d      = ex_mem_funct3;
                    data_d    = ex_mem_store_data;
                    rd_addr_d = ex_mem_rd_addr;
                    rd_wen_d  = ex_mem_rd_wen;
                    store_d   = ex_mem_mem_wen;
                end else if (ex_mem_valid) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = ex_mem_rd_addr;
                    wb_wen_d   = ex_mem_rd_wen & ~is_mem;
                    wb_data_d  = ex_mem_rd_data;
                    if (is_mem & al_mis) begin
                        trap_d  = 1'b1;
                        cause_d = ex_mem_mem_wen ? STORE_MISALIGN : LOAD_MISALIGN;
                        tpc_d   = ex_mem_pc;
                        tval_d  = 32'(ex_mem_addr);
                    end
                end
            end
            MEM_REQ: state_d = dbus_req_ready ? MEM_RESP : MEM_REQ;
            MEM_RESP: begin
                if (dbus_resp_valid) begin
                    state_d    = MEM_IDLE;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = rd_addr_q;
                    wb_wen_d   = rd_wen_q & ~store_q;
                    wb_data_d  = store_q ? '0 : al_load;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            data_q     <= '0;
            rd_addr_q  <= '0;
            rd_wen_q   <= 1'b0;
            store_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_wen_q   <= 1'b0;
            wb_data_q  <= '0;
            trap_q     <= 1'b0;
            cause_q    <= '0;
            tpc_q      <= '0;
            tval_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            data_q     <= data_d;
            rd_addr_q  <= rd_addr_d;
            rd_wen_q   <= rd_wen_d;
            store_q    <= store_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_wen_q   <= wb_wen_d;
            wb_data_q  <= wb_data_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
            tpc_q      <= tpc_d;
            tval_q     <= tval_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench with a spec-level model and a per-cycle MEM/WB and trap checker.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_mem_valid = 1'b0, ex_mem_mem_ren = 1'b0, ex_mem_mem_wen = 1'b0;
    logic [2:0]  ex_mem_funct3 = '0;
    logic [31:0] ex_mem_addr = '0, ex_mem_store_data = '0, ex_mem_rd_data = '0, ex_mem_pc = '0;
    logic [4:0]  ex_mem_rd_addr = '0;
    logic        ex_mem_rd_wen = 1'b0;
    logic        dbus_req_valid, dbus_req_ready = 1'b0, dbus_we, dbus_resp_valid = 1'b0;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
    logic [3:0]  dbus_wstrb;
    logic        mem_stall, mem_wb_valid, mem_wb_rd_wen, mem_csr_trap_valid;
    logic [4:0]  mem_wb_rd_addr;
    logic [31:0] mem_wb_rd_data, mem_csr_trap_cause, mem_csr_trap_pc, mem_csr_trap_tval;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_valid(ex_mem_valid), .ex_mem_mem_ren(ex_mem_mem_ren), .ex_mem_mem_wen(ex_mem_mem_wen),
        .ex_mem_funct3(ex_mem_funct3), .ex_mem_addr(ex_mem_addr), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_rd_wen(ex_mem_rd_wen), .ex_mem_rd_data(ex_mem_rd_data),
        .ex_mem_pc(ex_mem_pc),
        .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_resp_valid(dbus_resp_valid), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid), .mem_wb_rd_addr(mem_wb_rd_addr),
        .mem_wb_rd_wen(mem_wb_rd_wen), .mem_wb_rd_data(mem_wb_rd_data),
        .mem_csr_trap_valid(mem_csr_trap_valid), .mem_csr_trap_cause(mem_csr_trap_cause),
        .mem_csr_trap_pc(mem_csr_trap_pc), .mem_csr_trap_tval(mem_csr_trap_tval)
    );

    always #5 clk = ~clk;

    typedef struct {logic [4:0] rd; logic wen; logic [31:0] data;} exp_t;
    typedef struct {logic [31:0] cause; logic [31:0] pc; logic [31:0] tval;} trap_t;
    exp_t  exp_q[$];
    trap_t trap_q[$];
    int n_chk = 0, n_fail = 0;
    logic [31:0] last_rd_data, last_cause, last_tpc, last_tval, last_addr, last_wdata;
    logic        last_rd_wen, last_we;
    logic [3:0]  last_wstrb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wb_valid) begin
                if (exp_q.size() == 0) chk("wb_unexpected", 32'(mem_wb_valid), 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd_addr", 32'(mem_wb_rd_addr), 32'(e.rd));
                    chk("wb_rd_wen", 32'(mem_wb_rd_wen), 32'(e.wen));
                    if (e.wen) chk("wb_rd_data", mem_wb_rd_data, e.data);
                    last_rd_data = mem_wb_rd_data;
                    last_rd_wen  = mem_wb_rd_wen;
                end
            end
            if (mem_csr_trap_valid) begin
                if (trap_q.size() == 0) chk("trap_unexpected", 32'(mem_csr_trap_valid), 32'd0);
                else begin
                    trap_t t;
                    t = trap_q.pop_front();
                    chk("trap_cause", mem_csr_trap_cause, t.cause);
                    chk("trap_pc", mem_csr_trap_pc, t.pc);
                    chk("trap_tval", mem_csr_trap_tval, t.tval);
                    last_cause = mem_csr_trap_cause;
                    last_tpc   = mem_csr_trap_pc;
                    last_tval  = mem_csr_trap_tval;
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_op(input logic [2:0] f3, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic rdwen, input logic [31:0] rdd,
                          input logic [31:0] pc, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rdata);
        exp_t e;
        trap_t t;
        logic st, is_mem, legal, mis, bus;
        int sz, lo;
        logic [31:0] v, mask, wd;
        logic [3:0] ws;
        st     = wen;
        is_mem = ren | wen;
        sz     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        lo     = int'(addr % 4);
        legal  = st ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis    = is_mem && legal && (addr % sz != 0);
        bus    = is_mem && legal && !mis;
        v      = rdata >> (8 * lo);
        mask   = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v      = v & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        ws = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= lo && i < lo + sz) ws[i] = 1'b1;
            wd[8*i +: 8] = sdata[8*(i % sz) +: 8];
        end
        e.rd   = rd;
        e.wen  = is_mem ? (bus && !st && rdwen) : rdwen;
        e.data = is_mem ? v : rdd;
        exp_q.push_back(e);
        if (mis) begin
            t.cause = st ? 32'd6 : 32'd4;
            t.pc    = pc;
            t.tval  = addr;
            trap_q.push_back(t);
        end
        ex_mem_valid = 1'b1; ex_mem_mem_ren = ren; ex_mem_mem_wen = wen; ex_mem_funct3 = f3;
        ex_mem_addr = addr; ex_mem_store_data = sdata; ex_mem_rd_addr = rd; ex_mem_rd_wen = rdwen;
        ex_mem_rd_data = rdd; ex_mem_pc = pc;
        @(negedge clk);
        chk("stall_present", 32'(mem_stall), 32'(bus));
        chk("req_in_idle", 32'(dbus_req_valid), 32'd0);
        @(posedge clk); #1;
        if (bus) begin
            for (int i = 0; i < rdy_dly; i++) begin
                dbus_req_ready = 1'b0;
                @(negedge clk);
                chk("req_hold_valid", 32'(dbus_req_valid), 32'd1);
                chk("req_hold_addr", dbus_addr, addr & ~32'd3);
                chk("req_stall", 32'(mem_stall), 32'd1);
                chk("req_bubble", 32'(mem_wb_valid), 32'd0);
                @(posedge clk); #1;
            end
            dbus_req_ready = 1'b1;
            @(negedge clk);
            chk("req_valid", 32'(dbus_req_valid), 32'd1);
            chk("req_addr", dbus_addr, addr & ~32'd3);
            chk("req_we", 32'(dbus_we), 32'(st));
            if (st) begin
                chk("req_wstrb", 32'(dbus_wstrb), 32'(ws));
                chk("req_wdata", dbus_wdata, wd);
            end
            last_addr = dbus_addr; last_we = dbus_we; last_wstrb = dbus_wstrb; last_wdata = dbus_wdata;
            @(posedge clk); #1;
            dbus_req_ready = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                @(negedge clk);
                chk("resp_wait_stall", 32'(mem_stall), 32'd1);
                chk("resp_wait_req", 32'(dbus_req_valid), 32'd0);
                chk("resp_wait_bubble", 32'(mem_wb_valid), 32'd0);
                @(posedge clk); #1;
            end
            dbus_resp_valid = 1'b1; dbus_rdata = rdata;
            @(negedge clk);
            chk("resp_stall_release", 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            dbus_resp_valid = 1'b0; dbus_rdata = '0;
        end
        ex_mem_valid = 1'b0;
        @(negedge clk);
        chk("wb_latency", 32'(mem_wb_valid), 32'd1);
        chk("trap_valid", 32'(mem_csr_trap_valid), 32'(mis));
        @(posedge clk); #1;
        if (mis) begin
            @(negedge clk);
            chk("trap_one_cycle", 32'(mem_csr_trap_valid), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
        chk("rst_req_valid", 32'(dbus_req_valid), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_trap", 32'(mem_csr_trap_valid), 32'd0);
        chk("rst_wb_data", mem_wb_rd_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h100, 0, 0, 32'h0);
        chk("add_lit", last_rd_data, 32'h0000_1234);
        run_op(3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 5'd6, 1'b1, 32'h0, 32'h104, 0, 0, 32'h80FF_FF7F);
        chk("lb_lit", last_rd_data, 32'hFFFF_FF80);
        chk("lb_addr_lit", last_addr, 32'h0000_0100);
        run_op(3'b100, 1'b1, 1'b0, 32'h103, 32'h0, 5'd6, 1'b1, 32'h0, 32'h108, 0, 0, 32'h80FF_FF7F);
        chk("lbu_lit", last_rd_data, 32'h0000_0080);
        run_op(3'b001, 1'b0, 1'b1, 32'h202, 32'h0000_ABCD, 5'd7, 1'b1, 32'h0, 32'h10C, 0, 0, 32'h0);
        chk("sh_wstrb_lit", 32'(last_wstrb), 32'hC);
        chk("sh_wdata_lit", last_wdata, 32'hABCD_ABCD);
        chk("sh_we_lit", 32'(last_we), 32'd1);
        chk("sh_rdwen_lit", 32'(last_rd_wen), 32'd0);
        run_op(3'b010, 1'b1, 1'b0, 32'h40, 32'h0, 5'd8, 1'b1, 32'h0, 32'h110, 3, 2, 32'h1122_3344);
        chk("lw_lit", last_rd_data, 32'h1122_3344);
        run_op(3'b010, 1'b1, 1'b0, 32'h41, 32'h0, 5'd9, 1'b1, 32'h0, 32'h8000_0010, 0, 0, 32'h0);
        chk("lw_mis_cause_lit", last_cause, 32'd4);
        chk("lw_mis_tval_lit", last_tval, 32'h41);
        chk("lw_mis_pc_lit", last_tpc, 32'h8000_0010);
        run_op(3'b010, 1'b0, 1'b1, 32'h42, 32'h5555, 5'd9, 1'b0, 32'h0, 32'h8000_0014, 0, 0, 32'h0);
        chk("sw_mis_cause_lit", last_cause, 32'd6);
        run_op(3'b001, 1'b1, 1'b0, 32'h2, 32'h0, 5'd10, 1'b1, 32'h0, 32'h118, 1, 0, 32'h8001_0000);
        chk("lh_lit", last_rd_data, 32'hFFFF_8001);
        run_op(3'b101, 1'b1, 1'b0, 32'h6, 32'h0, 5'd11, 1'b1, 32'h0, 32'h11C, 0, 1, 32'h8001_0000);
        chk("lhu_lit", last_rd_data, 32'h0000_8001);
        run_op(3'b000, 1'b0, 1'b1, 32'h1, 32'h0000_005A, 5'd0, 1'b0, 32'h0, 32'h120, 0, 0, 32'h0);
        chk("sb_wstrb_lit", 32'(last_wstrb), 32'h2);
        chk("sb_wdata_lit", last_wdata, 32'h5A5A_5A5A);
        run_op(3'b011, 1'b1, 1'b0, 32'h0, 32'h0, 5'd12, 1'b1, 32'h77, 32'h124, 0, 0, 32'h0);
        run_op(3'b010, 1'b1, 1'b1, 32'h10, 32'hCAFE_BABE, 5'd13, 1'b1, 32'h0, 32'h128, 0, 0, 32'h0);
        chk("both_we_lit", 32'(last_we), 32'd1);
        chk("both_wstrb_lit", 32'(last_wstrb), 32'hF);
        run_op(3'b001, 1'b1, 1'b0, 32'h101, 32'h0, 5'd14, 1'b1, 32'h0, 32'h12C, 0, 0, 32'h0);
        chk("lh_mis_cause_lit", last_cause, 32'd4);
        @(negedge clk);
        chk("idle_bubble", 32'(mem_wb_valid), 32'd0);
        @(posedge clk); #1;
        ex_mem_valid = 1'b1; ex_mem_mem_ren = 1'b1; ex_mem_mem_wen = 1'b0; ex_mem_funct3 = 3'b010;
        ex_mem_addr = 32'h80; ex_mem_rd_addr = 5'd15; ex_mem_rd_wen = 1'b1; ex_mem_pc = 32'h130;
        dbus_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dbus_req_ready = 1'b0;
        rst_n = 1'b0;
        ex_mem_valid = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dbus_req_valid), 32'd0);
        chk("rst_mid_stall", 32'(mem_stall), 32'd0);
        chk("rst_mid_wb_valid", 32'(mem_wb_valid), 32'd0);
        chk("rst_mid_wb_addr", 32'(mem_wb_rd_addr), 32'd0);
        chk("rst_mid_wb_data", mem_wb_rd_data, 32'd0);
        chk("rst_mid_trap_cause", mem_csr_trap_cause, 32'd0);
        chk("rst_mid_dbus_addr", dbus_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dbus_resp_valid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stale_resp_stall", 32'(mem_stall), 32'd0);
        chk("stale_resp_req", 32'(dbus_req_valid), 32'd0);
        @(posedge clk); #1;
        dbus_resp_valid = 1'b0; dbus_rdata = '0;
        @(negedge clk);
        chk("stale_resp_ignored", 32'(mem_wb_valid), 32'd0);
        @(posedge clk); #1;
        run_op(3'b010, 1'b1, 1'b0, 32'h84, 32'h0, 5'd16, 1'b1, 32'h0, 32'h134, 0, 0, 32'h0BAD_F00D);
        chk("post_rst_lw_lit", last_rd_data, 32'h0BAD_F00D);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("trap_queue_drained", 32'(trap_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32 pipeline; sits directly downstream of the execute stage, fed through the EX/MEM register.
- Executes loads and stores against a valid/ready data bus. Performs byte-lane alignment and load sign/zero-extension, and detects misaligned accesses.
- Registers writeback results into MEM/WB and raises a stall to the hazard unit while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data bus/register width (fixed 32; parameter for documentation only)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_mem_valid  in  1  EX/MEM slot holds a live instruction
- ex_mem_mem_ren  in  1  load
- ex_mem_mem_wen  in  1  store
- ex_mem_funct3  in  3  access size/sign (RV32I load/store funct3)
- ex_mem_addr  in  32  effective address (ALU result)
- ex_mem_store_data  in  32  rs2 value for stores
- ex_mem_rd_addr  in  5  destination register
- ex_mem_rd_wen  in  1  destination write enable
- ex_mem_rd_data  in  32  ALU/CSR result for non-load instructions
- ex_mem_pc  in  32  instruction PC
- dbus_req_valid  out  1  bus request valid
- dbus_req_ready  in  1  bus accepts request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata  out  32  lane-shifted store data
- dbus_wstrb  out  4  byte strobes
- dbus_resp_valid  in  1  read data valid / write acknowledged
- dbus_rdata  in  32  read word
- mem_stall  out  1  hold EX/MEM and all upstream stages
- mem_wb_valid  out  1  MEM/WB slot live
- mem_wb_rd_addr  out  5
- mem_wb_rd_wen  out  1
- mem_wb_rd_data  out  32
- mem_csr_trap_valid  out  1  misaligned-access trap, one cycle
- mem_csr_trap_cause  out  32  4 = load misaligned, 6 = store misaligned
- mem_csr_trap_pc  out  32  faulting PC
- mem_csr_trap_tval  out  32  faulting address

Behaviour:
- Reset (asynchronous, active-low): FSM to IDLE. All mem_wb_*, mem_csr_*, dbus_* outputs and all internal latches are 0.
- FSM states:
  - IDLE: accepts a new instruction.
  - REQ: dbus_req_valid = 1; held stable until dbus_req_ready.
  - RESP: waits for dbus_resp_valid.
- Non-memory instruction in IDLE (valid, ren = wen = 0): the rd_* fields are registered into mem_wb_* next edge with mem_wb_valid = 1. Latency 1, no stall.
- Aligned memory op in IDLE:
  - Latch address, funct3, data, rd fields, and type; go to REQ.
  - mem_stall = 1 combinationally in this cycle.
- REQ:
  - mem_stall = 1, mem_wb_valid = 0.
  - On req_ready, go to RESP. A response in the same cycle as the request is ignored; the bus responds at earliest the next cycle.
- RESP:
  - mem_stall = 1 until dbus_resp_valid.
  - In the resp_valid cycle: mem_stall = 0 and go to IDLE. The load result (or store completion) is registered into mem_wb_* with mem_wb_valid = 1.
  - Stores force mem_wb_rd_wen = 0.
  - EX/MEM advances on that same edge; the stale op is not re-sampled.
- Minimum memory latency: 3 cycles from presentation to mem_wb_valid (ready and resp both immediate).
- mem_wb_valid is 0 (bubble) in every stall cycle.
- Load extraction: byte lane = addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store lanes:
  - SB: data[7:0] replicated to all lanes, wstrb = 0001 << addr[1:0].
  - SH: data[15:0] replicated, wstrb = 0011 << addr[1:0].
  - SW: wstrb = 1111.
- Misaligned (halfword with addr[0] = 1; word with addr[1:0] != 0):
  - No bus request, no stall.
  - Next edge: trap_valid = 1 for one cycle with cause/pc/tval.
  - mem_wb_valid = 1 and mem_wb_rd_wen = 0.
- Unsupported funct3 (loads 011/110/111; stores >010): no bus access, no trap, rd_wen = 0.
- ren and wen both set: store wins.
- ex_mem_valid = 0 in IDLE: mem_wb_valid = 0.
- Reset mid-transaction: immediate return to IDLE with dbus_req_valid dropped; any late response is ignored.

Decomposition:
- Add to define.v:
  - load/store funct3 codes (LB_F3 … SW_F3)
  - FSM state encodings MEM_IDLE/MEM_REQ/MEM_RESP
  - trap causes LOAD_MISALIGN = 4 and STORE_MISALIGN = 6
- One combinational sub-module, mem_align: store lane shift/wstrb generation, load extract/extend, and misalign detect.

Test Plan:
- ADD result 0x1234 to rd = 5, no mem -> next cycle mem_wb_valid = 1, rd_addr = 5, rd_data = 0x1234, stall never high.
- LB addr 0x103, rdata 0x80FF_FF7F, ready/resp immediate -> stall high 2 cycles; dbus_addr = 0x100; rd_data = 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH addr 0x202, data 0xABCD -> wstrb = 1100, wdata = 0xABCD_ABCD, we = 1, mem_wb_rd_wen = 0.
- LW addr 0x40, ready delayed 3 cycles, resp delayed 2 more -> dbus_req_valid/addr stable until ready; mem_wb_valid only after resp; stall released in the resp cycle.
- LW addr 0x41, pc 0x8000_0010 -> no dbus_req_valid; trap_valid one cycle, cause = 4, tval = 0x41, pc = 0x8000_0010; SW addr 0x42 -> cause = 6.
- rst_n low during RESP -> dbus_req_valid = 0 and all outputs 0 immediately; after release, a new LW completes normally and the stale resp is ignored.
